// File: rtl/pipe_mux_stage.sv
// pipe_mux_stage: NUM_IN-way word selector feeding a 2-entry elastic (skid) output register.
// Define SEL_CHECK_EN to add the sticky out-of-range select flag on sel_err.
module pipe_mux_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] outData_q;
  logic [WIDTH-1:0] skidData_q;
  logic             outValid_q;
  logic             inReady_q;
  logic [WIDTH-1:0] word_d;
  logic             accept;

  assign accept    = in_valid & inReady_q;
  assign in_ready  = inReady_q;
  assign out_data  = outData_q;
  assign out_valid = outValid_q;

  // Out-of-range selects match no input and leave the word at zero.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word_d = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else if (flush) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            outData_q  <= word_d;
            outValid_q <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (accept && out_ready) begin
            outData_q <= word_d;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the held one.
            skidData_q <= word_d;
            inReady_q  <= 1'b0;
            state_q    <= FULL;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            outData_q <= skidData_q;
            inReady_q <= 1'b1;
            state_q   <= BUSY;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

`ifdef SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic selErr_q;

  assign sel_err = selErr_q;

  // Sticky until reset; a word discarded by flush does not count as accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selErr_q <= 1'b0;
    end else if (accept && !flush && ({1'b0, sel} >= NUM_IN_W)) begin
      selErr_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Self-checking bench for pipe_mux_stage: queue scoreboard of accepted words plus occupancy checks.
// SEL_W=3 with NUM_IN=4 so that selects 4..7 exercise the out-of-range zero word.
module tb_pipe_mux_stage;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
`ifdef SEL_CHECK_EN
  logic                    sel_err;
`endif

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] expQ[$];
  logic expSelErr = 1'b0;
  logic lastAccept = 1'b0;

  always #5 clk = ~clk;

  pipe_mux_stage #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SEL_CHECK_EN
    ,
    .sel_err  (sel_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] modelWord(input logic [NUM_IN*WIDTH-1:0] d,
                                                 input logic [SEL_W-1:0] s);
    if (int'(s) < NUM_IN) return d[int'(s)*WIDTH +: WIDTH];
    return '0;
  endfunction

  // Compare on the falling edge, then predict what the next rising edge does.
  task automatic clockCycle();
    logic acc;
    logic emit;
    @(negedge clk);
    checkOutput("in_ready", WIDTH'(in_ready), WIDTH'(expQ.size() < 2));
    checkOutput("out_valid", WIDTH'(out_valid), WIDTH'(expQ.size() > 0));
    if (expQ.size() > 0) checkOutput("out_data", out_data, expQ[0]);
`ifdef SEL_CHECK_EN
    checkOutput("sel_err", WIDTH'(sel_err), WIDTH'(expSelErr));
`endif
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (flush) begin
      expQ.delete();
    end else begin
      if (emit && expQ.size() > 0) void'(expQ.pop_front());
      if (acc) begin
        expQ.push_back(modelWord(in_data, sel));
        if (int'(sel) >= NUM_IN) expSelErr = 1'b1;
      end
    end
    lastAccept = acc && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                               input logic r, input logic f);
    in_valid  = v;
    sel       = s;
    out_ready = r;
    flush     = f;
    clockCycle();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    in_data   = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    #12;
    checkOutput("rst_out_valid", WIDTH'(out_valid), '0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
`ifdef SEL_CHECK_EN
    checkOutput("rst_sel_err", WIDTH'(sel_err), '0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, one-cycle latency.
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    checkOutput("t1_data", out_data, 32'hCCCC_CCCC);
    checkOutput("t1_valid", WIDTH'(out_valid), WIDTH'(1));
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Back-to-back stream at full throughput.
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, SEL_W'(s), 1'b1, 1'b0);
    checkOutput("t2_last", out_data, 32'hDDDD_DDDD);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Stall into FULL, then drain in order.
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    checkOutput("t3_full_ready", WIDTH'(in_ready), '0);
    checkOutput("t3_full_data", out_data, 32'hAAAA_AAAA);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("t3_second", out_data, 32'hBBBB_BBBB);
    checkOutput("t3_ready_back", WIDTH'(in_ready), WIDTH'(1));
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Flush while FULL with a word offered.
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b1);
    checkOutput("t4_valid", WIDTH'(out_valid), '0);
    checkOutput("t4_ready", WIDTH'(in_ready), WIDTH'(1));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Out-of-range select gives a zero word; flag survives flush.
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
    checkOutput("t5_zero", out_data, '0);
    checkOutput("t5_valid", WIDTH'(out_valid), WIDTH'(1));
`ifdef SEL_CHECK_EN
    checkOutput("t5_sel_err", WIDTH'(sel_err), WIDTH'(1));
`endif
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges mid-stream.
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_valid", WIDTH'(out_valid), '0);
    checkOutput("t6_data", out_data, '0);
    checkOutput("t6_ready", WIDTH'(in_ready), WIDTH'(1));
`ifdef SEL_CHECK_EN
    checkOutput("t6_sel_err", WIDTH'(sel_err), '0);
`endif
    expQ.delete();
    expSelErr = 1'b0;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    // Random traffic; offered words are held until accepted.
    lastAccept = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !lastAccept)) begin
        in_valid = 1'($urandom_range(0, 1));
        sel      = SEL_W'($urandom_range(0, 7));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clockCycle();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
